// File: rtl/ctx_reg_file.sv
// Register file for the MIPS-32 OS core: 3 async reads, 1 sync write, link/cmd registers,
// plus a context save/load engine that streams the whole file over valid/ready handshakes.
module ctx_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 64,
  parameter int LINK_REG = 8,
  parameter int CMD_REG  = 40,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] readReg3,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] readData3,
  input  logic              writeReg,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              inCMD,
  input  logic              emit,
  input  logic              stored,
  input  logic [DATA_W-1:0] endereco,
  output logic              stored_OK,
  input  logic              swap_save,
  input  logic              swap_load,
  output logic              swap_busy,
  output logic              swap_done,
  output logic              sv_valid,
  input  logic              sv_ready,
  output logic [ADDR_W-1:0] sv_addr,
  output logic [DATA_W-1:0] sv_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, DONE} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] CMD_A    = ADDR_W'(CMD_REG);

  // One bit per address: 1 where a real, writable/readable register lives.
  function automatic logic [DEPTH-1:0] mk_mask();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = (i < NUM_REGS) && !(ZERO_R0 && (i == 0));
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] VALID_MASK = mk_mask();

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return VALID_MASK[a] ? regs[a] : '0;
  endfunction

  always_comb begin
    readData1 = emit ? rd(CMD_A) : rd(readReg1);
    readData2 = rd(readReg2);
    readData3 = rd(readReg3);
  end

  // Single write port: host writes only in IDLE (stored beats writeReg), load beats in LOAD.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    unique case (state)
      IDLE: begin
        if (stored) begin
          we    = 1'b1;
          waddr = LINK_A;
          wdata = endereco - DATA_W'(1);
        end else if (writeReg) begin
          we    = 1'b1;
          waddr = inCMD ? CMD_A : writeAddress;
          wdata = writeData;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          waddr = idx;
          wdata = ld_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && VALID_MASK[waddr]) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) stored_OK <= 1'b0;
    else        stored_OK <= (state == IDLE) && stored;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      unique case (state)
        SAVE:    if (sv_ready) idx <= idx + ADDR_W'(1);
        LOAD:    if (ld_valid) idx <= idx + ADDR_W'(1);
        default: idx <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (swap_save)      state_nxt = SAVE;
        else if (swap_load) state_nxt = LOAD;
      end
      SAVE:    if (sv_ready && idx == LAST_IDX) state_nxt = DONE;
      LOAD:    if (ld_valid && idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    swap_busy = 1'b0;
    swap_done = 1'b0;
    sv_valid  = 1'b0;
    ld_ready  = 1'b0;
    unique case (state)
      SAVE: begin
        swap_busy = 1'b1;
        sv_valid  = 1'b1;
      end
      LOAD: begin
        swap_busy = 1'b1;
        ld_ready  = 1'b1;
      end
      DONE:    swap_done = 1'b1;
      default: ;
    endcase
  end

  assign sv_addr = idx;
  assign sv_data = rd(idx);

endmodule
